// File: rtl/seg_sram_pkg.sv
// rtl/seg_sram_pkg.sv - shared widths and depths for the SRAM-backed stream FIFO
package seg_sram_pkg;
   localparam int DATA_WIDTH   = 24;
   localparam int ADDR_WIDTH   = 5;
   localparam int NUM_WMASKS   = DATA_WIDTH / 8;
   localparam int DEPTH        = 1 << ADDR_WIDTH;
   localparam int CNT_W        = ADDR_WIDTH + 1;
   localparam int LEVEL_W      = ADDR_WIDTH + 2;
   localparam int AFULL_THRESH = 28;
endpackage

// File: rtl/seg_skid_buf2.sv
// rtl/seg_skid_buf2.sv - 2-entry output buffer absorbing the macro's read latency
module seg_skid_buf2
   import seg_sram_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_clr,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_pop,
   output logic [1:0]            o_count,
   output logic [DATA_WIDTH-1:0] o_data
);
   logic [DATA_WIDTH-1:0] r_d0;
   logic [DATA_WIDTH-1:0] r_d1;
   logic [1:0]            r_cnt;

   // r_d0 is always the head; r_d1 only holds data when two words are present
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d0  <= '0;
         r_d1  <= '0;
         r_cnt <= 2'd0;
      end else if (i_clr) begin
         r_cnt <= 2'd0;
      end else begin
         case ({i_push, i_pop})
            2'b10: begin
               if (r_cnt == 2'd0) r_d0 <= i_data;
               else               r_d1 <= i_data;
               r_cnt <= r_cnt + 2'd1;
            end
            2'b01: begin
               r_d0  <= r_d1;
               r_cnt <= r_cnt - 2'd1;
            end
            2'b11: begin
               if (r_cnt == 2'd1) begin
                  r_d0 <= i_data;
               end else begin
                  r_d0 <= r_d1;
                  r_d1 <= i_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_count = r_cnt;
   assign o_data  = r_d0;
endmodule

// File: rtl/seg_sram_fifo.sv
// rtl/seg_sram_fifo.sv - stream FIFO driving a 1rw1r SRAM macro; SEG_SRAM_FIFO_AFULL_EN adds almost_full
module seg_sram_fifo
   import seg_sram_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [LEVEL_W-1:0]    level,
`ifdef SEG_SRAM_FIFO_AFULL_EN
   output logic                  almost_full,
`endif
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   output logic                  sram_csb1,
   output logic [ADDR_WIDTH-1:0] sram_addr1,
   input  logic [DATA_WIDTH-1:0] sram_dout1
);
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [CNT_W-1:0]      r_mem_count;
   logic                  r_rd_pend;
   logic [ADDR_WIDTH-1:0] r_addr0_hold;
   logic [DATA_WIDTH-1:0] r_din0_hold;
   logic [ADDR_WIDTH-1:0] r_addr1_hold;

   logic                  w_push;
   logic                  w_pop;
   logic                  w_issue;
   logic [1:0]            w_buf_cnt;
   logic [2:0]            w_occ;

   // Registered count only, so a slot freed by a same-cycle read is not reusable yet
   assign in_ready  = rst_n & ~flush & (r_mem_count < CNT_W'(DEPTH));
   assign w_push    = in_valid & in_ready;
   assign out_valid = (w_buf_cnt != 2'd0);
   assign w_pop     = out_valid & out_ready;

   // Issue only when the word returning next cycle is guaranteed a buffer slot
   assign w_occ   = {1'b0, w_buf_cnt} + {2'b00, r_rd_pend};
   assign w_issue = rst_n & ~flush & (r_mem_count != '0) & (w_occ < (3'd2 + {2'b00, w_pop}));

   assign sram_csb0   = ~w_push;
   assign sram_web0   = 1'b0;
   assign sram_wmask0 = '1;
   assign sram_addr0  = w_push ? r_wr_ptr : r_addr0_hold;
   assign sram_din0   = w_push ? in_data  : r_din0_hold;
   assign sram_csb1   = ~w_issue;
   assign sram_addr1  = w_issue ? r_rd_ptr : r_addr1_hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_mem_count <= '0;
         r_rd_pend   <= 1'b0;
      end else if (flush) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_mem_count <= '0;
         r_rd_pend   <= 1'b0;
      end else begin
         if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_mem_count <= r_mem_count + CNT_W'(w_push) - CNT_W'(w_issue);
         r_rd_pend   <= w_issue;
      end
   end

   // Idle SRAM address/data lines keep their last driven value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr0_hold <= '0;
         r_din0_hold  <= '0;
         r_addr1_hold <= '0;
      end else begin
         if (w_push) begin
            r_addr0_hold <= r_wr_ptr;
            r_din0_hold  <= in_data;
         end
         if (w_issue) r_addr1_hold <= r_rd_ptr;
      end
   end

   seg_skid_buf2 u_obuf (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (flush),
      .i_push  (r_rd_pend),
      .i_data  (sram_dout1),
      .i_pop   (w_pop),
      .o_count (w_buf_cnt),
      .o_data  (out_data)
   );

   assign level = LEVEL_W'(r_mem_count) + LEVEL_W'(r_rd_pend) + LEVEL_W'(w_buf_cnt);

`ifdef SEG_SRAM_FIFO_AFULL_EN
   // Issue and capture only move words internally, so the next level is level + push - pop
   logic [LEVEL_W-1:0] w_level_nxt;

   always_comb begin
      w_level_nxt = level;
      if (flush) w_level_nxt = '0;
      else       w_level_nxt = level + LEVEL_W'(w_push) - LEVEL_W'(w_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) almost_full <= 1'b0;
      else        almost_full <= (w_level_nxt >= LEVEL_W'(AFULL_THRESH));
   end
`endif
endmodule
